// File: rtl/l2s_loop_ctrl_if.sv
// Bundle of the monitored-state inputs and loop-status outputs of l2s_loop_ctrl.
// The master side drives state/requests; the slave side is the loop controller.
interface l2s_loop_ctrl_if #(
    parameter int STATE_W = 7,
    parameter int LEN_W   = 8
);
    logic               loop_start;
    logic [STATE_W-1:0] state_in;
    logic               bad_in;
    logic               loop_active;
    logic               loop_closed;
    logic               done;
    logic               bad_seen;
    logic               violation;
    logic               violation_sticky;
    logic [LEN_W-1:0]   cycle_len;

    modport master (
        output loop_start,
        output state_in,
        output bad_in,
        input  loop_active,
        input  loop_closed,
        input  done,
        input  bad_seen,
        input  violation,
        input  violation_sticky,
        input  cycle_len
    );

    modport slave (
        input  loop_start,
        input  state_in,
        input  bad_in,
        output loop_active,
        output loop_closed,
        output done,
        output bad_seen,
        output violation,
        output violation_sticky,
        output cycle_len
    );
endinterface

// File: rtl/l2s_loop_ctrl.sv
// Liveness-to-safety loop controller: snapshots a loop head, watches for the state to recur
// and flags a fair-violating lasso. Define L2S_CYCLE_LEN_EN to include the cycle_len counter.
module l2s_loop_ctrl #(
    parameter int STATE_W = 7,
    parameter int LEN_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    l2s_loop_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_CLOSED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [STATE_W-1:0] snap_q, snap_d;
    logic               bad_seen_q, bad_seen_d;
    logic               sticky_q, sticky_d;
    logic               closed_s;
    logic               viol_s;

    // Loop closure and violation detection against the held snapshot
    always_comb begin
        closed_s = 1'b0;
        if ((state_q == ST_TRACK) && (bus.state_in == snap_q)) begin
            closed_s = 1'b1;
        end else begin
            closed_s = 1'b0;
        end
        // bad_in of the closing cycle itself is deliberately not part of the lasso
        viol_s = closed_s & bad_seen_q;
    end

    // Next-state and register update logic
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        bad_seen_d = bad_seen_q;
        sticky_d   = sticky_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.loop_start) begin
                    state_d    = ST_TRACK;
                    snap_d     = bus.state_in;
                    bad_seen_d = bus.bad_in;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_TRACK: begin
                bad_seen_d = bad_seen_q | bus.bad_in;
                if (closed_s) begin
                    state_d  = ST_CLOSED;
                    sticky_d = sticky_q | viol_s;
                end else begin
                    state_d  = ST_TRACK;
                end
            end
            ST_CLOSED: begin
                state_d = ST_CLOSED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, snapshot and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            snap_q     <= {STATE_W{1'b0}};
            bad_seen_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            bad_seen_q <= bad_seen_d;
            sticky_q   <= sticky_d;
        end
    end

`ifdef L2S_CYCLE_LEN_EN
    logic [LEN_W-1:0] len_q, len_d;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + LEN_W'(1);
        end
    endfunction

    // Cycle length: 1 on capture, saturating count while tracking
    always_comb begin
        len_d = len_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.loop_start) begin
                    len_d = LEN_W'(1);
                end else begin
                    len_d = len_q;
                end
            end
            ST_TRACK: begin
                len_d = sat_inc(len_q);
            end
            default: begin
                len_d = len_q;
            end
        endcase
    end

    // Cycle length register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q <= {LEN_W{1'b0}};
        end else begin
            len_q <= len_d;
        end
    end

    assign bus.cycle_len = len_q;
`else
    assign bus.cycle_len = {LEN_W{1'b0}};
`endif

    // Status outputs decoded from the registered state
    always_comb begin
        bus.loop_active      = 1'b0;
        bus.done             = 1'b0;
        bus.loop_closed      = closed_s;
        bus.violation        = viol_s;
        bus.bad_seen         = bad_seen_q;
        bus.violation_sticky = sticky_q;
        if (state_q == ST_TRACK) begin
            bus.loop_active = 1'b1;
        end else begin
            bus.loop_active = 1'b0;
        end
        if (state_q == ST_CLOSED) begin
            bus.done = 1'b1;
        end else begin
            bus.done = 1'b0;
        end
    end

endmodule

// File: tb/tb_l2s_loop_ctrl.sv
// Directed bench for l2s_loop_ctrl; expected cycle_len follows whether L2S_CYCLE_LEN_EN is defined.
module tb_l2s_loop_ctrl;

`ifdef L2S_CYCLE_LEN_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    l2s_loop_ctrl_if #(.STATE_W(7), .LEN_W(8)) bus ();

    l2s_loop_ctrl #(.STATE_W(7), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] elen(input int n);
        if (!LEN_EN) return 32'd0;
        else if (n > 255) return 32'd255;
        else return 32'(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic act, input logic cl, input logic dn,
                           input logic bs, input logic vi, input logic vs, input logic [31:0] len);
        chk({tag, ".loop_active"}, 32'(bus.loop_active), 32'(act));
        chk({tag, ".loop_closed"}, 32'(bus.loop_closed), 32'(cl));
        chk({tag, ".done"}, 32'(bus.done), 32'(dn));
        chk({tag, ".bad_seen"}, 32'(bus.bad_seen), 32'(bs));
        chk({tag, ".violation"}, 32'(bus.violation), 32'(vi));
        chk({tag, ".violation_sticky"}, 32'(bus.violation_sticky), 32'(vs));
        chk({tag, ".cycle_len"}, 32'(bus.cycle_len), len);
    endtask

    // One cycle: drive inputs just after the rising edge, then let outputs settle
    task automatic cyc(input logic ls, input logic [6:0] st, input logic bad);
        @(posedge clk);
        #1;
        bus.loop_start = ls;
        bus.state_in   = st;
        bus.bad_in     = bad;
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk_all(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        bus.loop_start = 1'b0;
        bus.state_in   = 7'h00;
        bus.bad_in     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b0;
        bus.loop_start = 1'b0;
        bus.state_in   = 7'h00;
        bus.bad_in     = 1'b0;
        #12;
        do_reset("rst0");

        // Idle with no request: everything stays 0
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 7'(i * 13), 1'(i % 2));
            chk_all($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        end

        // Basic loop, no bad
        cyc(1'b1, 7'h15, 1'b0);
        chk_all("a.cap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 7'h16, 1'b0);
        chk_all("a.t1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, elen(1));
        cyc(1'b0, 7'h17, 1'b0);
        chk_all("a.t2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, elen(2));
        cyc(1'b0, 7'h15, 1'b0);
        chk_all("a.t3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, elen(3));
        cyc(1'b0, 7'h15, 1'b0);
        chk_all("a.done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, elen(4));

        // Loop with bad on second TRACK cycle
        do_reset("rst1");
        cyc(1'b1, 7'h15, 1'b0);
        cyc(1'b0, 7'h16, 1'b0);
        chk_all("b.t1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, elen(1));
        cyc(1'b0, 7'h17, 1'b1);
        chk_all("b.t2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, elen(2));
        cyc(1'b0, 7'h15, 1'b0);
        chk_all("b.t3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, elen(3));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 7'h15, 1'b1);
            chk_all($sformatf("b.cl%0d", i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, elen(4));
        end

        // Bad only on the closing cycle does not count
        do_reset("rst2");
        cyc(1'b1, 7'h05, 1'b0);
        cyc(1'b0, 7'h06, 1'b0);
        cyc(1'b0, 7'h05, 1'b1);
        chk_all("c.t2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, elen(2));
        cyc(1'b0, 7'h05, 1'b0);
        chk_all("c.done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, elen(3));

        // Close on the first TRACK cycle; bad captured together with the snapshot
        do_reset("rst3");
        cyc(1'b1, 7'h2a, 1'b1);
        cyc(1'b0, 7'h2a, 1'b0);
        chk_all("d.t1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, elen(1));
        cyc(1'b0, 7'h2a, 1'b0);
        chk_all("d.done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, elen(2));

        // Long track: counter saturates
        do_reset("rst4");
        cyc(1'b1, 7'h01, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            cyc(1'b0, 7'((i % 100) + 2), 1'b0);
            chk($sformatf("e.act%0d", i), 32'(bus.loop_active), 32'd1);
            chk($sformatf("e.len%0d", i), 32'(bus.cycle_len), elen(i));
        end

        // Asynchronous reset mid-TRACK at cycle_len 5
        do_reset("rst5");
        cyc(1'b1, 7'h33, 1'b0);
        cyc(1'b0, 7'h34, 1'b0);
        cyc(1'b0, 7'h35, 1'b1);
        cyc(1'b0, 7'h36, 1'b0);
        chk_all("f.t3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, elen(3));
        cyc(1'b0, 7'h37, 1'b0);
        cyc(1'b0, 7'h38, 1'b0);
        chk_all("f.t5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, elen(5));
        bus.state_in = 7'h33;
        do_reset("f.rst");
        cyc(1'b0, 7'h33, 1'b0);
        chk_all("f.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // loop_start in TRACK/CLOSED does not re-capture
        cyc(1'b1, 7'h10, 1'b0);
        cyc(1'b1, 7'h20, 1'b0);
        chk_all("g.t1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, elen(1));
        cyc(1'b0, 7'h20, 1'b0);
        chk_all("g.t2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, elen(2));
        cyc(1'b1, 7'h10, 1'b0);
        chk_all("g.t3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, elen(3));
        cyc(1'b1, 7'h44, 1'b0);
        cyc(1'b0, 7'h44, 1'b0);
        chk_all("g.cl", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, elen(4));
        cyc(1'b0, 7'h10, 1'b0);
        chk_all("g.cl2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, elen(4));
        do_reset("g.rst");
        cyc(1'b0, 7'h10, 1'b0);
        chk_all("g.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
